cache_mul10_arb: RTL

CACHE_MUL10_ARB -- requirements
Module: cache_mul10_arb

---
 rtl/cache_mul10_arb_if.sv | 24 ++
 rtl/cache_mul10_arb.sv | 107 ++++++++++
 2 files changed

// File: rtl/cache_mul10_arb_if.sv
// rtl/cache_mul10_arb_if.sv - request/response bus for the round-robin x10 multiplier
interface cache_mul10_arb_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_data;
  logic               rsp_valid;
  logic [19:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/cache_mul10_arb.sv
// rtl/cache_mul10_arb.sv - round-robin arbiter feeding a x10 stage and response FIFO
module cache_mul10_arb #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_mul10_arb_if.slave  bus,
  output logic [15:0]       issue_cnt
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    issue_q, issue_d;
  logic           s1_valid_q;
  logic [19:0]    s1_data_q, s1_data_d;
  logic [IDW-1:0] s1_id_q;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic [19:0]    mem_q [DEPTH];
  logic [IDW-1:0] id_mem_q [DEPTH];

  logic           credit_ok, found, accept, push, pop, rsp_valid;
  logic [IDW-1:0] winner;
  logic [15:0]    win_op;
  logic [NREQ-1:0] grant;

  // S1 occupies a slot; a pop this cycle only frees credit on the next one
  assign credit_ok = (int'(count_q) + int'(s1_valid_q)) < DEPTH;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found  = 1'b1;
        winner = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // rst gates the grant so nothing is offered while reset is held
  assign accept = found && credit_ok && rst;

  always_comb begin
    grant = '0;
    if (accept) grant[winner] = 1'b1;
  end

  always_comb begin
    win_op    = bus.req_data[16*winner +: 16];
    s1_data_d = ({4'b0, win_op} << 3) + ({4'b0, win_op} << 1);
  end

  assign push      = s1_valid_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && bus.rsp_ready;

  always_comb begin
    ptr_d   = ptr_q;
    issue_d = issue_q;
    if (accept) begin
      ptr_d   = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
      issue_d = issue_q + 16'd1;
    end
    wr_d    = push ? ((int'(wr_q) == DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d    = pop  ? ((int'(rd_q) == DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= '0;
      issue_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      issue_q    <= issue_d;
      s1_valid_q <= accept;
      s1_data_q  <= s1_data_d;
      s1_id_q    <= winner;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q]    <= s1_data_q;
      id_mem_q[wr_q] <= s1_id_q;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? mem_q[rd_q] : '0;
  assign bus.rsp_id    = rsp_valid ? id_mem_q[rd_q] : '0;
  assign issue_cnt     = issue_q;
endmodule
